// File: rtl/wt_read_arbiter_if.sv
// Bus bundle between the wavetable voice channels, the bank RAM read port and the read arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface wt_read_arbiter_if #(
    parameter int NUM_REQ   = 8,
    parameter int ADDRWIDTH = 8,
    parameter int BANKWIDTH = 2,
    parameter int DATAWIDTH = 16
);
    logic [NUM_REQ-1:0]             req_pulse;
    logic [NUM_REQ*BANKWIDTH-1:0]   req_bank;
    logic [NUM_REQ*ADDRWIDTH-1:0]   req_addr;
    logic                           ram_re;
    logic [BANKWIDTH+ADDRWIDTH-1:0] ram_raddr;
    logic [DATAWIDTH-1:0]           ram_rdata;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATAWIDTH-1:0]           rsp_data;
    logic                           busy;
    logic [NUM_REQ-1:0]             overrun;
    logic                           overrun_clr;

    modport slave (
        input  req_pulse, req_bank, req_addr, ram_rdata, overrun_clr,
        output ram_re, ram_raddr, rsp_valid, rsp_data, busy, overrun
    );

    modport master (
        output req_pulse, req_bank, req_addr, ram_rdata, overrun_clr,
        input  ram_re, ram_raddr, rsp_valid, rsp_data, busy, overrun
    );
endinterface

// File: rtl/wt_read_arbiter.sv
// Round-robin arbiter sharing the single wavetable RAM read port among NUM_REQ voice channels,
// one grant per cycle, with a one-hot tag pipeline steering each returned word to its channel.
module wt_read_arbiter #(
    parameter int NUM_REQ   = 8,
    parameter int ADDRWIDTH = 8,
    parameter int BANKWIDTH = 2,
    parameter int DATAWIDTH = 16,
    parameter int RAM_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    wt_read_arbiter_if.slave  bus
);
    localparam int PTRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RAW  = BANKWIDTH + ADDRWIDTH;

    logic [NUM_REQ-1:0]   r_pending;
    logic [RAW-1:0]       r_addrQ [NUM_REQ];
    logic [PTRW-1:0]      r_ptr;
    logic [NUM_REQ-1:0]   r_grantTag;
    logic [NUM_REQ-1:0]   r_tagPipe [RAM_LAT];
    logic                 r_ramRe;
    logic [RAW-1:0]       r_ramRaddr;
    logic [NUM_REQ-1:0]   r_rspValid;
    logic [DATAWIDTH-1:0] r_rspData;
    logic [NUM_REQ-1:0]   r_overrun;

    logic                 w_grantValid;
    logic [PTRW-1:0]      w_grantIdx;
    logic [PTRW-1:0]      w_ptrNext;
    logic [NUM_REQ-1:0]   w_grantOneHot;
    logic [NUM_REQ-1:0]   w_overrunSet;
    logic                 w_tagBusy;

    // Scan pending flags starting at the pointer; the first hit wins, wrapping explicitly
    // so that non-power-of-two channel counts never index past NUM_REQ-1.
    always_comb begin : grantSelect
        logic [PTRW:0] cand;
        cand         = '0;
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, r_ptr} + (PTRW+1)'(k);
            if (cand >= (PTRW+1)'(NUM_REQ)) begin
                cand = cand - (PTRW+1)'(NUM_REQ);
            end
            if (!w_grantValid && r_pending[cand[PTRW-1:0]]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = cand[PTRW-1:0];
            end
        end
    end

    always_comb begin
        w_grantOneHot = '0;
        if (w_grantValid) begin
            w_grantOneHot[w_grantIdx] = 1'b1;
        end
        w_ptrNext = (w_grantIdx == PTRW'(NUM_REQ-1)) ? '0 : w_grantIdx + PTRW'(1);
        // A re-request only overruns when the older request is not being served right now.
        w_overrunSet = bus.req_pulse & r_pending & ~w_grantOneHot;
        w_tagBusy = 1'b0;
        for (int k = 0; k < RAM_LAT; k++) begin
            w_tagBusy = w_tagBusy | (|r_tagPipe[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_ptr      <= '0;
            r_grantTag <= '0;
            r_ramRe    <= 1'b0;
            r_ramRaddr <= '0;
            r_rspValid <= '0;
            r_rspData  <= '0;
            r_overrun  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_addrQ[i] <= '0;
            end
            for (int k = 0; k < RAM_LAT; k++) begin
                r_tagPipe[k] <= '0;
            end
        end else begin
            r_ramRe    <= w_grantValid;
            r_grantTag <= w_grantOneHot;
            if (w_grantValid) begin
                r_ramRaddr <= r_addrQ[w_grantIdx];
                r_ptr      <= w_ptrNext;
            end

            // The grant reads the old address, so a same-cycle re-request simply re-arms the flag.
            r_pending <= (r_pending & ~w_grantOneHot) | bus.req_pulse;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_pulse[i]) begin
                    r_addrQ[i] <= {bus.req_bank[i*BANKWIDTH +: BANKWIDTH],
                                   bus.req_addr[i*ADDRWIDTH +: ADDRWIDTH]};
                end
            end

            r_overrun <= (bus.overrun_clr ? '0 : r_overrun) | w_overrunSet;

            r_tagPipe[0] <= r_grantTag;
            for (int k = 1; k < RAM_LAT; k++) begin
                r_tagPipe[k] <= r_tagPipe[k-1];
            end

            if (|r_tagPipe[RAM_LAT-1]) begin
                r_rspValid <= r_tagPipe[RAM_LAT-1];
                r_rspData  <= bus.ram_rdata;
            end else begin
                r_rspValid <= '0;
            end
        end
    end

    assign bus.ram_re    = r_ramRe;
    assign bus.ram_raddr = r_ramRaddr;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_data  = r_rspData;
    assign bus.overrun   = r_overrun;
    assign bus.busy      = (|r_pending) | w_tagBusy | r_ramRe | (|r_grantTag);

endmodule

// File: tb/tb_wt_read_arbiter.sv
// Directed bench for wt_read_arbiter: one task per scenario with hand-computed expectations
// and a small behavioural RAM that returns a fixed function of the read address.
module tb_wt_read_arbiter;
    localparam int NUM_REQ   = 8;
    localparam int ADDRWIDTH = 8;
    localparam int BANKWIDTH = 2;
    localparam int DATAWIDTH = 16;
    localparam int RAM_LAT   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nCompared   = 0;
    int   nMismatched = 0;

    always #5 clk = ~clk;

    wt_read_arbiter_if #(
        .NUM_REQ(NUM_REQ), .ADDRWIDTH(ADDRWIDTH), .BANKWIDTH(BANKWIDTH), .DATAWIDTH(DATAWIDTH)
    ) bus ();

    wt_read_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDRWIDTH(ADDRWIDTH), .BANKWIDTH(BANKWIDTH),
        .DATAWIDTH(DATAWIDTH), .RAM_LAT(RAM_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] ramWord(input logic [9:0] a);
        return 16'hC3A5 ^ {a[5:0], a};
    endfunction

    // Reads without ram_re return a poison word so misaligned capture is visible.
    logic [DATAWIDTH-1:0] rdPipe [RAM_LAT];
    always_ff @(posedge clk) begin
        rdPipe[0] <= bus.ram_re ? ramWord(bus.ram_raddr) : 16'hDEAD;
        for (int k = 1; k < RAM_LAT; k++) begin
            rdPipe[k] <= rdPipe[k-1];
        end
    end
    assign bus.ram_rdata = rdPipe[RAM_LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.req_pulse   = '0;
        bus.overrun_clr = 1'b0;
    endtask

    task automatic setReq(input int ch, input logic [1:0] bank, input logic [7:0] addr);
        bus.req_pulse[ch] = 1'b1;
        bus.req_bank[ch*BANKWIDTH +: BANKWIDTH] = bank;
        bus.req_addr[ch*ADDRWIDTH +: ADDRWIDTH] = addr;
    endtask

    task automatic pulseReset();
        clearInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clearInputs();
        bus.req_bank = '0;
        bus.req_addr = '0;
        rst = 1'b1;
        tick(); tick(); tick();
        nCompared++; if (bus.ram_re !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ram_re: got %0h want 0", bus.ram_re); end
        nCompared++; if (bus.ram_raddr !== 10'h000) begin nMismatched++; $display("[TB] FAIL reset_raddr: got %0h want 0", bus.ram_raddr); end
        nCompared++; if (bus.rsp_valid !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_rsp_valid: got %0h want 0", bus.rsp_valid); end
        nCompared++; if (bus.rsp_data !== 16'h0000) begin nMismatched++; $display("[TB] FAIL reset_rsp_data: got %0h want 0", bus.rsp_data); end
        nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %0h want 0", bus.busy); end
        nCompared++; if (bus.overrun !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_overrun: got %0h want 0", bus.overrun); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        pulseReset();
        setReq(3, 2'd2, 8'h41);
        tick();
        clearInputs();
        nCompared++; if (bus.busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_busy: got %0h want 1", bus.busy); end
        tick();
        nCompared++; if (bus.ram_re !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_re: got %0h want 1", bus.ram_re); end
        nCompared++; if (bus.ram_raddr !== 10'h241) begin nMismatched++; $display("[TB] FAIL single_raddr: got %0h want 241", bus.ram_raddr); end
        tick();
        nCompared++; if (bus.rsp_valid !== 8'h00) begin nMismatched++; $display("[TB] FAIL single_early_rsp: got %0h want 0", bus.rsp_valid); end
        tick();
        nCompared++; if (bus.rsp_valid !== 8'h08) begin nMismatched++; $display("[TB] FAIL single_rsp_valid: got %0h want 08", bus.rsp_valid); end
        nCompared++; if (bus.rsp_data !== ramWord(10'h241)) begin nMismatched++; $display("[TB] FAIL single_rsp_data: got %0h want %0h", bus.rsp_data, ramWord(10'h241)); end
        tick();
        nCompared++; if (bus.rsp_valid !== 8'h00) begin nMismatched++; $display("[TB] FAIL single_rsp_drop: got %0h want 0", bus.rsp_valid); end
        nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_idle: got %0h want 0", bus.busy); end
    endtask

    task automatic test_contention();
        logic [9:0] expA;
        logic [7:0] expV;
        pulseReset();
        for (int c = 0; c < NUM_REQ; c++) setReq(c, 2'(c % 4), 8'(16 + c));
        tick();
        clearInputs();
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k <= 8) begin
                expA = {2'((k-1) % 4), 8'(16 + k - 1)};
                nCompared++; if (bus.ram_re !== 1'b1 || bus.ram_raddr !== expA) begin nMismatched++; $display("[TB] FAIL contention_grant%0d: got re=%0h addr=%0h want re=1 addr=%0h", k, bus.ram_re, bus.ram_raddr, expA); end
            end else begin
                nCompared++; if (bus.ram_re !== 1'b0) begin nMismatched++; $display("[TB] FAIL contention_idle%0d: got re=%0h want 0", k, bus.ram_re); end
            end
            if (k >= 3) begin
                expV = 8'(1 << (k - 3));
                expA = {2'((k-3) % 4), 8'(16 + k - 3)};
                nCompared++; if (bus.rsp_valid !== expV || bus.rsp_data !== ramWord(expA)) begin nMismatched++; $display("[TB] FAIL contention_rsp%0d: got v=%0h d=%0h want v=%0h d=%0h", k, bus.rsp_valid, bus.rsp_data, expV, ramWord(expA)); end
            end else begin
                nCompared++; if (bus.rsp_valid !== 8'h00) begin nMismatched++; $display("[TB] FAIL contention_early%0d: got %0h want 0", k, bus.rsp_valid); end
            end
        end
        nCompared++; if (bus.overrun !== 8'h00) begin nMismatched++; $display("[TB] FAIL contention_overrun: got %0h want 0", bus.overrun); end
        nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL contention_busy: got %0h want 0", bus.busy); end
    endtask

    task automatic test_fairness();
        logic [9:0] expAddr [1:6];
        logic [7:0] expV;
        expAddr[1] = 10'h000; expAddr[2] = 10'h050; expAddr[3] = 10'h001;
        expAddr[4] = 10'h051; expAddr[5] = 10'h002; expAddr[6] = 10'h052;
        pulseReset();
        setReq(0, 2'd0, 8'h00);
        setReq(5, 2'd0, 8'h50);
        tick();
        clearInputs();
        for (int k = 1; k <= 8; k++) begin
            if (k == 2 || k == 4) setReq(0, 2'd0, 8'(k / 2));
            if (k == 3 || k == 5) setReq(5, 2'd0, 8'(8'h50 + (k - 1) / 2));
            tick();
            clearInputs();
            if (k <= 6) begin
                nCompared++; if (bus.ram_re !== 1'b1 || bus.ram_raddr !== expAddr[k]) begin nMismatched++; $display("[TB] FAIL fair_grant%0d: got re=%0h addr=%0h want re=1 addr=%0h", k, bus.ram_re, bus.ram_raddr, expAddr[k]); end
            end else begin
                nCompared++; if (bus.ram_re !== 1'b0) begin nMismatched++; $display("[TB] FAIL fair_idle%0d: got re=%0h want 0", k, bus.ram_re); end
            end
            if (k >= 3) begin
                expV = ((k - 2) % 2 == 1) ? 8'h01 : 8'h20;
                nCompared++; if (bus.rsp_valid !== expV || bus.rsp_data !== ramWord(expAddr[k-2])) begin nMismatched++; $display("[TB] FAIL fair_rsp%0d: got v=%0h d=%0h want v=%0h d=%0h", k, bus.rsp_valid, bus.rsp_data, expV, ramWord(expAddr[k-2])); end
            end
        end
        nCompared++; if (bus.overrun !== 8'h00) begin nMismatched++; $display("[TB] FAIL fair_overrun: got %0h want 0", bus.overrun); end
    endtask

    task automatic test_overrun();
        pulseReset();
        setReq(0, 2'd0, 8'hA0);
        setReq(1, 2'd0, 8'hA1);
        tick();
        clearInputs();
        setReq(2, 2'd0, 8'h10);
        tick();
        clearInputs();
        nCompared++; if (bus.ram_raddr !== 10'h0A0 || bus.overrun !== 8'h00) begin nMismatched++; $display("[TB] FAIL ovr_first: got addr=%0h ovr=%0h want addr=0a0 ovr=0", bus.ram_raddr, bus.overrun); end
        setReq(2, 2'd0, 8'h20);
        tick();
        clearInputs();
        nCompared++; if (bus.ram_raddr !== 10'h0A1 || bus.overrun !== 8'h04) begin nMismatched++; $display("[TB] FAIL ovr_set: got addr=%0h ovr=%0h want addr=0a1 ovr=04", bus.ram_raddr, bus.overrun); end
        tick();
        nCompared++; if (bus.ram_re !== 1'b1 || bus.ram_raddr !== 10'h020) begin nMismatched++; $display("[TB] FAIL ovr_latest: got re=%0h addr=%0h want re=1 addr=020", bus.ram_re, bus.ram_raddr); end
        tick();
        nCompared++; if (bus.ram_re !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovr_single_read: got re=%0h want 0", bus.ram_re); end
        tick();
        nCompared++; if (bus.rsp_valid !== 8'h04 || bus.rsp_data !== ramWord(10'h020)) begin nMismatched++; $display("[TB] FAIL ovr_rsp: got v=%0h d=%0h want v=04 d=%0h", bus.rsp_valid, bus.rsp_data, ramWord(10'h020)); end
        tick();
        nCompared++; if (bus.overrun !== 8'h04 || bus.rsp_valid !== 8'h00) begin nMismatched++; $display("[TB] FAIL ovr_hold: got ovr=%0h v=%0h want ovr=04 v=0", bus.overrun, bus.rsp_valid); end
        bus.overrun_clr = 1'b1;
        tick();
        clearInputs();
        nCompared++; if (bus.overrun !== 8'h00) begin nMismatched++; $display("[TB] FAIL ovr_clear: got %0h want 0", bus.overrun); end
        // Pointer now sits at 3, so ch0 is served ahead of ch2.
        setReq(0, 2'd0, 8'hB0);
        setReq(2, 2'd0, 8'hB2);
        tick();
        clearInputs();
        setReq(2, 2'd0, 8'hB3);
        bus.overrun_clr = 1'b1;
        tick();
        clearInputs();
        nCompared++; if (bus.overrun !== 8'h04 || bus.ram_raddr !== 10'h0B0) begin nMismatched++; $display("[TB] FAIL ovr_set_beats_clr: got ovr=%0h addr=%0h want ovr=04 addr=0b0", bus.overrun, bus.ram_raddr); end
        tick();
        nCompared++; if (bus.ram_raddr !== 10'h0B3) begin nMismatched++; $display("[TB] FAIL ovr_latest2: got %0h want 0b3", bus.ram_raddr); end
        tick(); tick();
        bus.overrun_clr = 1'b1;
        tick();
        clearInputs();
        nCompared++; if (bus.overrun !== 8'h00) begin nMismatched++; $display("[TB] FAIL ovr_clear2: got %0h want 0", bus.overrun); end
    endtask

    task automatic test_back_to_back();
        pulseReset();
        setReq(4, 2'd1, 8'h32);
        tick();
        clearInputs();
        setReq(4, 2'd1, 8'h33);
        tick();
        clearInputs();
        nCompared++; if (bus.ram_re !== 1'b1 || bus.ram_raddr !== 10'h132) begin nMismatched++; $display("[TB] FAIL collide_old: got re=%0h addr=%0h want re=1 addr=132", bus.ram_re, bus.ram_raddr); end
        tick();
        nCompared++; if (bus.ram_re !== 1'b1 || bus.ram_raddr !== 10'h133) begin nMismatched++; $display("[TB] FAIL collide_new: got re=%0h addr=%0h want re=1 addr=133", bus.ram_re, bus.ram_raddr); end
        nCompared++; if (bus.overrun !== 8'h00) begin nMismatched++; $display("[TB] FAIL collide_overrun: got %0h want 0", bus.overrun); end
        tick();
        nCompared++; if (bus.ram_re !== 1'b0 || bus.rsp_valid !== 8'h10 || bus.rsp_data !== ramWord(10'h132)) begin nMismatched++; $display("[TB] FAIL collide_rsp1: got re=%0h v=%0h d=%0h want re=0 v=10 d=%0h", bus.ram_re, bus.rsp_valid, bus.rsp_data, ramWord(10'h132)); end
        tick();
        nCompared++; if (bus.rsp_valid !== 8'h10 || bus.rsp_data !== ramWord(10'h133)) begin nMismatched++; $display("[TB] FAIL collide_rsp2: got v=%0h d=%0h want v=10 d=%0h", bus.rsp_valid, bus.rsp_data, ramWord(10'h133)); end
        tick();
        nCompared++; if (bus.rsp_valid !== 8'h00 || bus.overrun !== 8'h00) begin nMismatched++; $display("[TB] FAIL collide_end: got v=%0h ovr=%0h want 0 0", bus.rsp_valid, bus.overrun); end
    endtask

    task automatic test_reset_midflight();
        pulseReset();
        setReq(1, 2'd0, 8'h11);
        setReq(2, 2'd0, 8'h12);
        setReq(3, 2'd0, 8'h13);
        setReq(6, 2'd0, 8'h16);
        tick();
        clearInputs();
        tick();
        nCompared++; if (bus.ram_re !== 1'b1 || bus.ram_raddr !== 10'h011 || bus.busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL midrst_inflight: got re=%0h addr=%0h busy=%0h want 1 011 1", bus.ram_re, bus.ram_raddr, bus.busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nCompared++; if (bus.busy !== 1'b0 || bus.ram_re !== 1'b0 || bus.rsp_valid !== 8'h00) begin nMismatched++; $display("[TB] FAIL midrst_cleared: got busy=%0h re=%0h v=%0h want 0 0 0", bus.busy, bus.ram_re, bus.rsp_valid); end
        for (int k = 0; k < 5; k++) begin
            tick();
            nCompared++; if (bus.rsp_valid !== 8'h00 || bus.ram_re !== 1'b0 || bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_quiet%0d: got v=%0h re=%0h busy=%0h want 0 0 0", k, bus.rsp_valid, bus.ram_re, bus.busy); end
        end
        // With the pointer back at 0, ch0 must win over ch7.
        setReq(7, 2'd1, 8'h77);
        setReq(0, 2'd2, 8'h41);
        tick();
        clearInputs();
        tick();
        nCompared++; if (bus.ram_re !== 1'b1 || bus.ram_raddr !== 10'h241) begin nMismatched++; $display("[TB] FAIL midrst_ptr: got re=%0h addr=%0h want re=1 addr=241", bus.ram_re, bus.ram_raddr); end
        tick();
        nCompared++; if (bus.ram_raddr !== 10'h177) begin nMismatched++; $display("[TB] FAIL midrst_second: got %0h want 177", bus.ram_raddr); end
        tick();
        nCompared++; if (bus.rsp_valid !== 8'h01 || bus.rsp_data !== ramWord(10'h241)) begin nMismatched++; $display("[TB] FAIL midrst_rsp0: got v=%0h d=%0h want v=01 d=%0h", bus.rsp_valid, bus.rsp_data, ramWord(10'h241)); end
        tick();
        nCompared++; if (bus.rsp_valid !== 8'h80 || bus.rsp_data !== ramWord(10'h177)) begin nMismatched++; $display("[TB] FAIL midrst_rsp7: got v=%0h d=%0h want v=80 d=%0h", bus.rsp_valid, bus.rsp_data, ramWord(10'h177)); end
    endtask

    initial begin
        $display("[TB] wt_read_arbiter directed bench");
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_overrun();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
